// File: rtl/branch_predictor_if.sv
// Fetch-side lookup and EX-side resolution signals of the branch predictor.
// The pipeline drives through the master modport; the predictor uses slave.
interface branch_predictor_if;
  logic [31:0] PC_IF;
  logic        predictIF;
  logic [31:0] predTargetIF;
  logic        bubbleE;
  logic [31:0] PC_EX;
  logic        predictEX;
  logic        brEX;
  logic        takenEX;
  logic [31:0] targetEX;
  logic        mispredictEX;
  logic [31:0] redirectPC;
  logic [31:0] brCount;
  logic [31:0] missCount;

  modport master (
    output PC_IF, bubbleE, PC_EX, predictEX, brEX, takenEX, targetEX,
    input  predictIF, predTargetIF, mispredictEX, redirectPC, brCount, missCount
  );

  modport slave (
    input  PC_IF, bubbleE, PC_EX, predictEX, brEX, takenEX, targetEX,
    output predictIF, predTargetIF, mispredictEX, redirectPC, brCount, missCount
  );
endinterface

// File: rtl/branch_predictor.sv
// IF-stage branch predictor: direct-mapped BTB, 2-bit saturating counter per
// entry, combinational mispredict/redirect for EX, and branch/miss statistics.
// Reads are pre-edge: an EX update on the same index is seen by IF next cycle.
module branch_predictor #(
  parameter int         IDX_BITS = 6,
  parameter logic [1:0] CNT_INIT = 2'b01
) (
  input  logic               clk,
  input  logic               rst_n,
  branch_predictor_if.slave  bp
);

  localparam int ENTRIES  = 1 << IDX_BITS;
  localparam int TAG_BITS = 30 - IDX_BITS;

  // Counter helpers: saturate at the strong ends instead of wrapping.
  function automatic logic [1:0] sat_inc(input logic [1:0] c);
    return (c == 2'b11) ? 2'b11 : c + 2'b01;
  endfunction

  function automatic logic [1:0] sat_dec(input logic [1:0] c);
    return (c == 2'b00) ? 2'b00 : c - 2'b01;
  endfunction

  logic                valid_q  [ENTRIES];
  logic                valid_d  [ENTRIES];
  logic [TAG_BITS-1:0] tag_q    [ENTRIES];
  logic [TAG_BITS-1:0] tag_d    [ENTRIES];
  logic [31:0]         target_q [ENTRIES];
  logic [31:0]         target_d [ENTRIES];
  logic [1:0]          cnt_q    [ENTRIES];
  logic [1:0]          cnt_d    [ENTRIES];
  logic [31:0]         br_count_q, br_count_d;
  logic [31:0]         miss_count_q, miss_count_d;

  logic [IDX_BITS-1:0] idx_if, idx_ex;
  logic [TAG_BITS-1:0] tag_if, tag_ex;
  logic                hit_if, hit_ex;
  logic                predict_if;
  logic                mispredict;
  logic [31:0]         redirect_pc;
  logic                unused_ok;

  assign idx_if = bp.PC_IF[IDX_BITS+1:2];
  assign tag_if = bp.PC_IF[31:IDX_BITS+2];
  assign idx_ex = bp.PC_EX[IDX_BITS+1:2];
  assign tag_ex = bp.PC_EX[31:IDX_BITS+2];

  // Byte offset of PCs is irrelevant to a word-aligned BTB.
  assign unused_ok = ^{bp.PC_IF[1:0], bp.PC_EX[1:0]};

  assign hit_if = valid_q[idx_if] && (tag_q[idx_if] == tag_if);
  assign hit_ex = valid_q[idx_ex] && (tag_q[idx_ex] == tag_ex);

  // Fetch-side prediction from the pre-edge table contents.
  always_comb begin
    predict_if      = hit_if & cnt_q[idx_if][1];
    bp.predictIF    = predict_if;
    if (predict_if) begin
      bp.predTargetIF = target_q[idx_if];
    end else begin
      bp.predTargetIF = bp.PC_IF + 32'd4;
    end
  end

  // Resolve the EX instruction against the prediction it carried.
  always_comb begin
    mispredict  = 1'b0;
    redirect_pc = bp.PC_EX + 32'd4;
    if (bp.brEX) begin
      if (bp.takenEX && !bp.predictEX) begin
        mispredict  = 1'b1;
        redirect_pc = bp.targetEX;
      end else if (!bp.takenEX && bp.predictEX) begin
        mispredict  = 1'b1;
      end else begin
        mispredict  = 1'b0;
      end
    end else if (bp.predictEX) begin
      // Predicted-taken non-branch: BTB aliasing, fall through.
      mispredict = 1'b1;
    end else begin
      mispredict = 1'b0;
    end
    bp.mispredictEX = mispredict;
    bp.redirectPC   = redirect_pc;
  end

  // Training and statistics next-state; a bubbled EX leaves everything as is.
  always_comb begin
    valid_d      = valid_q;
    tag_d        = tag_q;
    target_d     = target_q;
    cnt_d        = cnt_q;
    br_count_d   = br_count_q;
    miss_count_d = miss_count_q;
    if (!bp.bubbleE) begin
      if (bp.brEX) begin
        br_count_d = br_count_q + 32'd1;
        if (hit_ex) begin
          if (bp.takenEX) begin
            cnt_d[idx_ex]    = sat_inc(cnt_q[idx_ex]);
            target_d[idx_ex] = bp.targetEX;
          end else begin
            cnt_d[idx_ex]    = sat_dec(cnt_q[idx_ex]);
          end
        end else if (bp.takenEX) begin
          // Allocate weakly taken, evicting whatever lived at this index.
          valid_d[idx_ex]  = 1'b1;
          tag_d[idx_ex]    = tag_ex;
          target_d[idx_ex] = bp.targetEX;
          cnt_d[idx_ex]    = 2'b10;
        end else begin
          valid_d[idx_ex]  = valid_q[idx_ex];
        end
      end else if (bp.predictEX && hit_ex) begin
        valid_d[idx_ex] = 1'b0;
      end else begin
        valid_d[idx_ex] = valid_q[idx_ex];
      end
      if (mispredict) begin
        miss_count_d = miss_count_q + 32'd1;
      end else begin
        miss_count_d = miss_count_q;
      end
    end else begin
      br_count_d = br_count_q;
    end
  end

  // Table and counter state; async reset clears the BTB immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        cnt_q[i]    <= CNT_INIT;
      end
      br_count_q   <= '0;
      miss_count_q <= '0;
    end else begin
      valid_q      <= valid_d;
      tag_q        <= tag_d;
      target_q     <= target_d;
      cnt_q        <= cnt_d;
      br_count_q   <= br_count_d;
      miss_count_q <= miss_count_d;
    end
  end

  assign bp.brCount   = br_count_q;
  assign bp.missCount = miss_count_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Bench for branch_predictor: directed vector table, hand sequences for
// wrap and async reset, then randomized traffic against a reference model.
module tb_branch_predictor;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_pass = 0;
  int   n_total = 0;

  branch_predictor_if bp ();

  branch_predictor #(.IDX_BITS(6), .CNT_INIT(2'b01)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bp    (bp)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc_if;
    logic [31:0] pc_ex;
    logic        pred;
    logic        br;
    logic        taken;
    logic [31:0] tgt;
    logic        bub;
    logic        e_pif;
    logic [31:0] e_ptgt;
    logic        e_mis;
    logic [31:0] e_redir;
    logic [31:0] e_br;
    logic [31:0] e_miss;
  } row_t;

  row_t rows[$];

  // Reference model: one record per BTB slot, plain integers.
  int unsigned m_valid  [64];
  int unsigned m_tag    [64];
  int unsigned m_target [64];
  int          m_cnt    [64];
  int unsigned m_br, m_miss;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", nm, act, exp);
  endtask

  task automatic add(input logic [31:0] pc_if, pc_ex, input logic pred, br, taken,
                     input logic [31:0] tgt, input logic bub, input logic e_pif,
                     input logic [31:0] e_ptgt, input logic e_mis,
                     input logic [31:0] e_redir, e_br, e_miss);
    rows.push_back('{pc_if, pc_ex, pred, br, taken, tgt, bub,
                     e_pif, e_ptgt, e_mis, e_redir, e_br, e_miss});
  endtask

  task automatic drive(input logic [31:0] pc_if, pc_ex, input logic pred, br, taken,
                       input logic [31:0] tgt, input logic bub);
    bp.PC_IF = pc_if; bp.PC_EX = pc_ex; bp.predictEX = pred; bp.brEX = br;
    bp.takenEX = taken; bp.targetEX = tgt; bp.bubbleE = bub;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 64; i++) begin
      m_valid[i] = 0; m_tag[i] = 0; m_target[i] = 0; m_cnt[i] = 1;
    end
    m_br = 0; m_miss = 0;
  endtask

  function automatic int unsigned slot(input logic [31:0] pc);
    return (int'(pc) >>> 0) >= 0 ? (pc / 4) % 64 : 0;
  endfunction

  function automatic bit m_hit(input logic [31:0] pc);
    return (m_valid[slot(pc)] != 0) && (m_tag[slot(pc)] == pc / 256);
  endfunction

  // Compare DUT outputs with the model for the currently driven inputs.
  task automatic model_check();
    bit          exp_pif, actual_taken, exp_mis;
    int unsigned exp_ptgt, exp_redir;
    exp_pif  = m_hit(bp.PC_IF) && (m_cnt[slot(bp.PC_IF)] >= 2);
    exp_ptgt = exp_pif ? m_target[slot(bp.PC_IF)] : bp.PC_IF + 4;
    actual_taken = bp.brEX && bp.takenEX;
    exp_mis   = (actual_taken != bp.predictEX);
    exp_redir = (exp_mis && actual_taken) ? bp.targetEX : bp.PC_EX + 4;
    chk("rnd_predictIF", {31'd0, bp.predictIF}, {31'd0, exp_pif});
    chk("rnd_predTargetIF", bp.predTargetIF, exp_ptgt);
    chk("rnd_mispredictEX", {31'd0, bp.mispredictEX}, {31'd0, exp_mis});
    chk("rnd_redirectPC", bp.redirectPC, exp_redir);
    chk("rnd_brCount", bp.brCount, m_br);
    chk("rnd_missCount", bp.missCount, m_miss);
  endtask

  // Apply one clock edge's worth of training to the model.
  task automatic model_update();
    int unsigned s;
    bit          h, mis;
    s   = slot(bp.PC_EX);
    h   = m_hit(bp.PC_EX);
    mis = ((bp.brEX && bp.takenEX) != bp.predictEX);
    if (!bp.bubbleE) begin
      if (bp.brEX) begin
        m_br++;
        if (h && bp.takenEX) begin
          m_cnt[s] = (m_cnt[s] + 1 > 3) ? 3 : m_cnt[s] + 1;
          m_target[s] = bp.targetEX;
        end else if (h) begin
          m_cnt[s] = (m_cnt[s] - 1 < 0) ? 0 : m_cnt[s] - 1;
        end else if (bp.takenEX) begin
          m_valid[s] = 1; m_tag[s] = bp.PC_EX / 256;
          m_target[s] = bp.targetEX; m_cnt[s] = 2;
        end
      end else if (bp.predictEX && h) begin
        m_valid[s] = 0;
      end
      if (mis) m_miss++;
    end
  endtask

  initial begin
    // pc_if, pc_ex, pred, br, taken, tgt, bub | pIF, pTgt, mis, redir, br, miss
    add(32'h100, 32'h0,   1'b0, 1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 32'h104, 1'b0, 32'h4,   32'd0, 32'd0);
    add(32'h100, 32'h100, 1'b0, 1'b1, 1'b1, 32'h200, 1'b0, 1'b0, 32'h104, 1'b1, 32'h200, 32'd0, 32'd0);
    add(32'h100, 32'h0,   1'b0, 1'b0, 1'b0, 32'h0,   1'b0, 1'b1, 32'h200, 1'b0, 32'h4,   32'd1, 32'd1);
    add(32'h100, 32'h100, 1'b1, 1'b1, 1'b0, 32'h200, 1'b0, 1'b1, 32'h200, 1'b1, 32'h104, 32'd1, 32'd1);
    add(32'h100, 32'h100, 1'b0, 1'b1, 1'b0, 32'h200, 1'b0, 1'b0, 32'h104, 1'b0, 32'h104, 32'd2, 32'd2);
    add(32'h100, 32'h0,   1'b0, 1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 32'h104, 1'b0, 32'h4,   32'd3, 32'd2);
    add(32'h100, 32'h100, 1'b0, 1'b1, 1'b1, 32'h300, 1'b0, 1'b0, 32'h104, 1'b1, 32'h300, 32'd3, 32'd2);
    add(32'h100, 32'h100, 1'b0, 1'b1, 1'b1, 32'h300, 1'b0, 1'b0, 32'h104, 1'b1, 32'h300, 32'd4, 32'd3);
    add(32'h100, 32'h0,   1'b0, 1'b0, 1'b0, 32'h0,   1'b0, 1'b1, 32'h300, 1'b0, 32'h4,   32'd5, 32'd4);
    // Index alias with a different tag: mispredicts, but misses so entry stays.
    add(32'h100, 32'h200, 1'b1, 1'b0, 1'b0, 32'h0,   1'b0, 1'b1, 32'h300, 1'b1, 32'h204, 32'd5, 32'd4);
    add(32'h100, 32'h0,   1'b0, 1'b0, 1'b0, 32'h0,   1'b0, 1'b1, 32'h300, 1'b0, 32'h4,   32'd5, 32'd5);
    // Non-branch that hits: entry invalidated.
    add(32'h100, 32'h100, 1'b1, 1'b0, 1'b0, 32'h0,   1'b0, 1'b1, 32'h300, 1'b1, 32'h104, 32'd5, 32'd5);
    add(32'h100, 32'h0,   1'b0, 1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 32'h104, 1'b0, 32'h4,   32'd5, 32'd6);
    for (int k = 0; k < 3; k++)
      add(32'h100, 32'h100, 1'b0, 1'b1, 1'b1, 32'h400, 1'b1, 1'b0, 32'h104, 1'b1, 32'h400, 32'd5, 32'd6);
    add(32'h100, 32'h100, 1'b0, 1'b1, 1'b1, 32'h400, 1'b0, 1'b0, 32'h104, 1'b1, 32'h400, 32'd5, 32'd6);
    add(32'h100, 32'h0,   1'b0, 1'b0, 1'b0, 32'h0,   1'b0, 1'b1, 32'h400, 1'b0, 32'h4,   32'd6, 32'd7);
    for (int k = 0; k < 5; k++)
      add(32'h100, 32'h100, 1'b1, 1'b1, 1'b1, 32'h400, 1'b0, 1'b1, 32'h400, 1'b0, 32'h104, 32'd6 + k, 32'd7);
    add(32'h100, 32'h100, 1'b1, 1'b1, 1'b0, 32'h400, 1'b0, 1'b1, 32'h400, 1'b1, 32'h104, 32'd11, 32'd7);
    add(32'h100, 32'h0,   1'b0, 1'b0, 1'b0, 32'h0,   1'b0, 1'b1, 32'h400, 1'b0, 32'h4,   32'd12, 32'd8);

    drive(32'h100, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    foreach (rows[i]) begin
      drive(rows[i].pc_if, rows[i].pc_ex, rows[i].pred, rows[i].br, rows[i].taken,
            rows[i].tgt, rows[i].bub);
      #2;
      chk($sformatf("row%0d_predictIF", i), {31'd0, bp.predictIF}, {31'd0, rows[i].e_pif});
      chk($sformatf("row%0d_predTargetIF", i), bp.predTargetIF, rows[i].e_ptgt);
      chk($sformatf("row%0d_mispredictEX", i), {31'd0, bp.mispredictEX}, {31'd0, rows[i].e_mis});
      chk($sformatf("row%0d_redirectPC", i), bp.redirectPC, rows[i].e_redir);
      chk($sformatf("row%0d_brCount", i), bp.brCount, rows[i].e_br);
      chk($sformatf("row%0d_missCount", i), bp.missCount, rows[i].e_miss);
      @(posedge clk);
      #1;
    end

    // missCount wrap: preload all-ones, then one aliasing mispredict (tag miss).
    dut.miss_count_q = 32'hFFFF_FFFF;
    drive(32'h100, 32'h500, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    #2;
    chk("wrap_pre_missCount", bp.missCount, 32'hFFFF_FFFF);
    chk("wrap_mispredictEX", {31'd0, bp.mispredictEX}, 32'd1);
    @(posedge clk);
    #1;
    chk("wrap_missCount", bp.missCount, 32'd0);
    chk("wrap_brCount", bp.brCount, 32'd12);

    // Async reset between edges clears tables at once; no update while low.
    drive(32'h100, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    #1;
    chk("arst_pre_predictIF", {31'd0, bp.predictIF}, 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_predictIF", {31'd0, bp.predictIF}, 32'd0);
    chk("arst_predTargetIF", bp.predTargetIF, 32'h104);
    chk("arst_brCount", bp.brCount, 32'd0);
    chk("arst_missCount", bp.missCount, 32'd0);
    drive(32'h100, 32'h100, 1'b0, 1'b1, 1'b1, 32'h200, 1'b0);
    @(posedge clk);
    #1;
    chk("arst_hold_brCount", bp.brCount, 32'd0);
    chk("arst_hold_predictIF", {31'd0, bp.predictIF}, 32'd0);
    drive(32'h100, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    rst_n = 1'b1;
    #2;
    chk("arst_rel_predictIF", {31'd0, bp.predictIF}, 32'd0);
    chk("arst_rel_mispredictEX", {31'd0, bp.mispredictEX}, 32'd0);
    @(posedge clk);
    #1;

    // Randomized traffic over a small PC pool so entries hit and alias.
    model_reset();
    for (int c = 0; c < 1500; c++) begin
      logic [31:0] pc_a, pc_b;
      pc_a = ($urandom_range(0, 3) << 8) | ($urandom_range(0, 7) << 2);
      pc_b = ($urandom_range(0, 3) << 8) | ($urandom_range(0, 7) << 2);
      drive(pc_a, pc_b, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 9) < 6),
            1'($urandom_range(0, 1)), $urandom & 32'hFFFF_FFFC,
            1'($urandom_range(0, 99) < 15));
      #2;
      model_check();
      model_update();
      @(posedge clk);
      #1;
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
